dvp_pixel_tx: RTL and testbench

DVP_PIXEL_TX -- requirements
Module: dvp_pixel_tx

---
 rtl/dvp_pixel_tx.sv | 133 +++++++++++++
 tb/tb_dvp_pixel_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dvp_pixel_tx.sv
// DVP camera-style transmitter: streams RGB565 pixels from a FWFT source as
// a byte-wide DVP stream (vsync/href/data) with configurable frame timing.
module dvp_pixel_tx #(
  parameter int H_PIXEL = 800,
  parameter int V_PIXEL = 480,
  parameter int H_BLANK = 64,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 4,
  parameter int V_FRONT = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        tx_en,
  input  logic [15:0] pix_data,
  input  logic        pix_empty,
  output logic        pix_req,
  output logic        ov_vsync,
  output logic        ov_href,
  output logic [7:0]  ov_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic        underflow
);
  localparam logic [11:0] LINE_LAST = 12'(2 * H_PIXEL + H_BLANK - 1);
  localparam logic [11:0] ACT_COLS  = 12'(2 * H_PIXEL);

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

  state_t      state_reg, state_next;
  logic [11:0] col_reg, col_next, line_reg, line_next;
  logic [11:0] phase_last;
  logic        line_end, phase_end, frame_end;
  logic        pix_req_reg, pix_req_next;
  logic        vsync_reg, vsync_next, href_reg, href_next;
  logic [7:0]  data_reg, data_next, lo_byte_reg, lo_byte_next;
  logic        fs_reg, fs_next, fd_reg, fd_next, uf_reg, uf_next;

  // Phase boundaries; a zero-length phase is never entered, so its value is moot.
  always_comb begin
    phase_last = '0;
    case (state_reg)
      VSYNC:   phase_last = 12'(V_SYNC - 1);
      VBACK:   phase_last = 12'(V_BACK - 1);
      ACTIVE:  phase_last = 12'(V_PIXEL - 1);
      VFRONT:  phase_last = 12'(V_FRONT - 1);
      default: phase_last = '0;
    endcase
  end

  assign line_end  = (col_reg == LINE_LAST);
  assign phase_end = line_end && (line_reg == phase_last);
  assign frame_end = phase_end &&
                     ((state_reg == VFRONT) || ((state_reg == ACTIVE) && (V_FRONT == 0)));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (tx_en) state_next = VSYNC;
      VSYNC:   if (phase_end) state_next = (V_BACK > 0) ? VBACK : ACTIVE;
      VBACK:   if (phase_end) state_next = ACTIVE;
      ACTIVE:  if (phase_end) state_next = frame_end ? (tx_en ? VSYNC : IDLE) : VFRONT;
      VFRONT:  if (phase_end) state_next = tx_en ? VSYNC : IDLE;
      default: state_next = IDLE;
    endcase

    col_next  = '0;
    line_next = '0;
    if ((state_reg != IDLE) && !phase_end) begin
      col_next  = line_end ? 12'd0 : col_reg + 12'd1;
      line_next = line_end ? line_reg + 12'd1 : line_reg;
    end
  end

  // Outputs are registered from the current state, so they trail the counters
  // by one clock; pix_req looks at the next state so the source word is on
  // pix_data exactly when its high byte is being registered.
  always_comb begin
    pix_req_next = (state_next == ACTIVE) && (col_next < ACT_COLS) && !col_next[0];
    vsync_next   = (state_reg == VSYNC);
    href_next    = (state_reg == ACTIVE) && (col_reg < ACT_COLS);
    fs_next      = (state_reg == VSYNC) && (col_reg == '0) && (line_reg == '0);
    fd_next      = frame_end;

    lo_byte_next = lo_byte_reg;
    if (pix_req_reg) lo_byte_next = pix_empty ? 8'h00 : pix_data[7:0];

    data_next = 8'h00;
    if (href_next) begin
      if (col_reg[0]) data_next = lo_byte_reg;
      else            data_next = pix_empty ? 8'h00 : pix_data[15:8];
    end

    uf_next = uf_reg;
    if (fs_next) uf_next = 1'b0;
    if (pix_req_reg && pix_empty) uf_next = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg   <= IDLE;
      col_reg     <= '0;
      line_reg    <= '0;
      pix_req_reg <= 1'b0;
      vsync_reg   <= 1'b0;
      href_reg    <= 1'b0;
      data_reg    <= 8'h00;
      lo_byte_reg <= 8'h00;
      fs_reg      <= 1'b0;
      fd_reg      <= 1'b0;
      uf_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      col_reg     <= col_next;
      line_reg    <= line_next;
      pix_req_reg <= pix_req_next;
      vsync_reg   <= vsync_next;
      href_reg    <= href_next;
      data_reg    <= data_next;
      lo_byte_reg <= lo_byte_next;
      fs_reg      <= fs_next;
      fd_reg      <= fd_next;
      uf_reg      <= uf_next;
    end
  end

  assign pix_req     = pix_req_reg;
  assign ov_vsync    = vsync_reg;
  assign ov_href     = href_reg;
  assign ov_data     = data_reg;
  assign frame_start = fs_reg;
  assign frame_done  = fd_reg;
  assign underflow   = uf_reg;
endmodule

// File: tb/tb_dvp_pixel_tx.sv
// Directed bench for dvp_pixel_tx: records a per-cycle trace of the DVP outputs
// and compares it with hand-derived frame timing and byte content.
module tb_dvp_pixel_tx;
  localparam int HP = 4, VP = 2, HB = 3, VS = 1, VB = 1, VF = 1;
  localparam int LL = 2 * HP + HB;
  localparam int FR = LL * (VS + VB + VP + VF);
  localparam int N  = 400;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        tx_en = 1'b0;
  logic [15:0] pix_data;
  logic        pix_empty;
  logic        pix_req, ov_vsync, ov_href, frame_start, frame_done, underflow;
  logic [7:0]  ov_data;

  always #5 sys_clk = ~sys_clk;

  dvp_pixel_tx #(
    .H_PIXEL(HP), .V_PIXEL(VP), .H_BLANK(HB),
    .V_SYNC(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_en(tx_en),
    .pix_data(pix_data), .pix_empty(pix_empty), .pix_req(pix_req),
    .ov_vsync(ov_vsync), .ov_href(ov_href), .ov_data(ov_data),
    .frame_start(frame_start), .frame_done(frame_done), .underflow(underflow)
  );

  logic [15:0] src [8] = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718,
                           16'h293A, 16'h4B5C, 16'h6D7E, 16'h8F90};
  logic [15:0] exp_norm [8] = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718,
                                16'h293A, 16'h4B5C, 16'h6D7E, 16'h8F90};
  logic [15:0] exp_uf [8] = '{16'hA1B2, 16'hC3D4, 16'h0000, 16'hE5F6,
                              16'h0718, 16'h293A, 16'h4B5C, 16'h6D7E};

  int vectors = 0, miscompares = 0;
  int cyc, req_num, src_idx, empty_req;
  logic       t_vs [N], t_hr [N], t_rq [N], t_fs [N], t_fd [N], t_uf [N];
  logic [7:0] t_dat [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_src();
    req_num   = 0;
    src_idx   = 0;
    pix_data  = src[0];
    pix_empty = (empty_req == 0);
  endtask

  // FWFT source model: a request pops the head unless the source reports empty.
  task automatic tick();
    logic req_seen, emp_seen;
    req_seen = pix_req;
    emp_seen = pix_empty;
    @(posedge sys_clk);
    #1;
    if (req_seen) begin
      req_num++;
      if (!emp_seen) src_idx++;
    end
    pix_data  = src[src_idx % 8];
    pix_empty = (req_num == empty_req);
    if (cyc < N) begin
      t_vs[cyc] = ov_vsync;  t_hr[cyc] = ov_href;     t_rq[cyc] = pix_req;
      t_fs[cyc] = frame_start; t_fd[cyc] = frame_done; t_uf[cyc] = underflow;
      t_dat[cyc] = ov_data;
    end
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  function automatic int cnt(input int sel, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i < hi && i < N; i++) begin
      case (sel)
        0: n += int'(t_fs[i]);
        1: n += int'(t_fd[i]);
        2: n += int'(t_vs[i]);
        3: n += int'(t_rq[i]);
        default: n += int'(t_uf[i]);
      endcase
    end
    return n;
  endfunction

  function automatic int first_fs(input int lo, input int hi);
    for (int i = lo; i < hi && i < N; i++) if (t_fs[i]) return i;
    return -1;
  endfunction

  // Frame offset k relative to frame_start; the active region begins (VS+VB) lines in.
  task automatic check_frame(input string tag, input int f, input logic [15:0] exp_w [8]);
    int hr_err, vs_err, rq_err, fd_err, z_err, nb, a, a1;
    logic e_hr, e_rq;
    logic [7:0] b [16];
    hr_err = 0; vs_err = 0; rq_err = 0; fd_err = 0; z_err = 0; nb = 0;
    for (int i = 0; i < 16; i++) b[i] = 8'h00;
    if (f < 0 || f + FR > N) begin
      check({tag, "_window"}, 32'(f), 32'(N));
      return;
    end
    for (int k = 0; k < FR; k++) begin
      a  = k - (VS + VB) * LL;
      a1 = a + 1;
      e_hr = (a >= 0) && (a < VP * LL) && ((a % LL) < 2 * HP);
      e_rq = (a1 >= 0) && (a1 < VP * LL) && ((a1 % LL) < 2 * HP) && ((a1 % LL) % 2 == 0);
      if (t_hr[f + k] !== e_hr) hr_err++;
      if (t_rq[f + k] !== e_rq) rq_err++;
      if (t_vs[f + k] !== (k < VS * LL)) vs_err++;
      if (t_fd[f + k] !== (k == FR - 1)) fd_err++;
      if (!t_hr[f + k] && t_dat[f + k] !== 8'h00) z_err++;
      if (t_hr[f + k]) begin
        if (nb < 16) b[nb] = t_dat[f + k];
        nb++;
      end
    end
    check({tag, "_href_timing"}, 32'(hr_err), 0);
    check({tag, "_req_timing"}, 32'(rq_err), 0);
    check({tag, "_vsync_timing"}, 32'(vs_err), 0);
    check({tag, "_done_timing"}, 32'(fd_err), 0);
    check({tag, "_blank_data"}, 32'(z_err), 0);
    check({tag, "_byte_count"}, 32'(nb), 32'(2 * HP * VP));
    for (int w = 0; w < 8; w++)
      check($sformatf("%s_word%0d", tag, w), {16'h0, b[2 * w], b[2 * w + 1]}, {16'h0, exp_w[w]});
  endtask

  initial begin
    int f, f2;
    empty_req = -1;
    cyc = 0;
    start_src();

    // Reset, with tx_en rising during reset: reset must win.
    repeat (2) tick();
    tx_en = 1'b1;
    tick();
    check("rst_pix_req", pix_req, 0);
    check("rst_vsync", ov_vsync, 0);
    check("rst_href", ov_href, 0);
    check("rst_data", ov_data, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_underflow", underflow, 0);

    // Basic + continuous frames, then tx_en dropped mid-ACTIVE of the third frame.
    sys_rst = 1'b0;
    cyc = 0;
    start_src();
    run_to(1 + 2 * FR + 25);
    tx_en = 1'b0;
    run_to(220);
    f = first_fs(0, 220);
    check("s1_frame_start_at", 32'(f), 1);
    check_frame("s1", f, exp_norm);
    check("s1_underflow_clear", 32'(cnt(4, 0, 220)), 0);
    check("s2_second_start", 32'(first_fs(f + 1, 220)), 32'(f + FR));
    check_frame("s2", f + FR, exp_norm);
    check("s2_req_per_frame", 32'(cnt(3, f + FR, f + 2 * FR)), 8);
    check_frame("s4", f + 2 * FR, exp_norm);
    check("s4_no_restart", 32'(cnt(0, f + 2 * FR + 1, 220)), 0);
    check("s4_no_vsync_after", 32'(cnt(2, f + 3 * FR, 220)), 0);
    check("s4_done_count", 32'(cnt(1, 0, 220)), 3);

    // Underflow on the third pixel request.
    sys_rst = 1'b1;
    tx_en   = 1'b1;
    repeat (2) tick();
    empty_req = 2;
    sys_rst = 1'b0;
    cyc = 0;
    start_src();
    run_to(1 + FR + 5);
    f = first_fs(0, N);
    check("s3_frame_start_at", 32'(f), 1);
    check_frame("s3", f, exp_uf);
    check("s3_uf_before", t_uf[f + 25], 0);
    check("s3_uf_set", t_uf[f + 26], 1);
    check("s3_uf_sticky", t_uf[f + FR - 1], 1);
    check("s3_uf_cleared", t_uf[f + FR], 0);

    // Reset pulsed on the third href byte, then a clean restart.
    sys_rst = 1'b1;
    repeat (2) tick();
    empty_req = -1;
    sys_rst = 1'b0;
    cyc = 0;
    start_src();
    run_to(26);
    check("s5_third_byte", {t_hr[25], t_dat[25]}, 9'h1C3);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    start_src();
    check("s5_all_zero", {t_vs[26], t_hr[26], t_rq[26], t_fs[26], t_fd[26], t_uf[26], t_dat[26]}, 0);
    run_to(28 + FR + 2);
    f2 = first_fs(2, N);
    check("s5_restart_at", 32'(f2), 28);
    check("s5_no_done_truncated", 32'(cnt(1, 0, f2 + FR - 1)), 0);
    check_frame("s5", f2, exp_norm);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
